// File: rtl/go_pkg.sv
// Shared types and constants for the Go board controller: cell encoding,
// default board size and the controller state enum.
package go_pkg;

    localparam int BOARD_N = 9;

    typedef logic [1:0] cell_t;

    localparam cell_t EMPTY = 2'b00;
    localparam cell_t BLACK = 2'b01;
    localparam cell_t WHITE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        CLEAR,
        OVER
    } state_t;

    function automatic cell_t other_player(cell_t p);
        return (p == BLACK) ? WHITE : BLACK;
    endfunction

endpackage

// File: rtl/go_cursor.sv
// Cursor position register with saturating moves, an enable gate and a
// synchronous recentre used when a new game starts.
module go_cursor #(
    parameter int BOARD_N = go_pkg::BOARD_N
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       center_i,
    input  logic       up_i,
    input  logic       down_i,
    input  logic       left_i,
    input  logic       right_i,
    output logic [3:0] row_o,
    output logic [3:0] col_o
);

    localparam logic [3:0] MAX_POS = 4'(BOARD_N - 1);
    localparam logic [3:0] CENTER  = 4'(BOARD_N / 2);

    logic [3:0] row_q, row_d;
    logic [3:0] col_q, col_d;

    // Opposing pulses on one axis cancel; each axis is handled independently.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (center_i) begin
            row_d = CENTER;
            col_d = CENTER;
        end else if (en_i) begin
            if (up_i && !down_i && row_q != 4'd0) begin
                row_d = row_q - 4'd1;
            end else if (down_i && !up_i && row_q != MAX_POS) begin
                row_d = row_q + 4'd1;
            end
            if (left_i && !right_i && col_q != 4'd0) begin
                col_d = col_q - 4'd1;
            end else if (right_i && !left_i && col_q != MAX_POS) begin
                col_d = col_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_q <= CENTER;
            col_q <= CENTER;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row_o = row_q;
    assign col_o = col_q;

endmodule

// File: rtl/go_board_ctrl.sv
// Go board controller: flop-array board, turn/pass bookkeeping and the
// IDLE/CHECK/CLEAR/OVER sequencer driving placement and the clear sweep.
module go_board_ctrl #(
    parameter int BOARD_N = go_pkg::BOARD_N
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 btn_up,
    input  logic                                 btn_down,
    input  logic                                 btn_left,
    input  logic                                 btn_right,
    input  logic                                 btn_place,
    input  logic                                 btn_pass,
    input  logic                                 btn_clear,
    output logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board,
    output logic [3:0]                           cursor_row,
    output logic [3:0]                           cursor_col,
    output logic [1:0]                           turn,
    output logic                                 busy,
    output logic                                 illegal,
    output logic                                 game_over
);

    import go_pkg::*;

    localparam logic [3:0] MAX_POS = 4'(BOARD_N - 1);

    logic [BOARD_N-1:0][BOARD_N-1:0][1:0] board_q;

    state_t     state_q, state_d;
    cell_t      turn_q, turn_d;
    logic       pass_q, pass_d;
    logic       illegal_q, illegal_d;
    logic       busy_q, busy_d;
    logic       over_q, over_d;
    logic [3:0] tgt_row_q, tgt_row_d;
    logic [3:0] tgt_col_q, tgt_col_d;
    logic [3:0] clr_row_q, clr_row_d;
    logic [3:0] clr_col_q, clr_col_d;

    logic       wr_en;
    logic [3:0] wr_row;
    logic [3:0] wr_col;
    cell_t      wr_val;
    logic       center_load;
    logic       cursor_en;

    assign cursor_en = (state_q == IDLE) || (state_q == OVER);

    go_cursor #(
        .BOARD_N (BOARD_N)
    ) u_cursor (
        .clk      (clk),
        .reset    (reset),
        .en_i     (cursor_en),
        .center_i (center_load),
        .up_i     (btn_up),
        .down_i   (btn_down),
        .left_i   (btn_left),
        .right_i  (btn_right),
        .row_o    (cursor_row),
        .col_o    (cursor_col)
    );

    // Clear outranks everything; otherwise the current state decides.
    always_comb begin
        state_d     = state_q;
        turn_d      = turn_q;
        pass_d      = pass_q;
        illegal_d   = 1'b0;
        tgt_row_d   = tgt_row_q;
        tgt_col_d   = tgt_col_q;
        clr_row_d   = clr_row_q;
        clr_col_d   = clr_col_q;
        wr_en       = 1'b0;
        wr_row      = 4'd0;
        wr_col      = 4'd0;
        wr_val      = EMPTY;
        center_load = 1'b0;

        if (btn_clear) begin
            state_d   = CLEAR;
            clr_row_d = 4'd0;
            clr_col_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (btn_place) begin
                        state_d   = CHECK;
                        tgt_row_d = cursor_row;
                        tgt_col_d = cursor_col;
                    end else if (btn_pass) begin
                        if (pass_q) begin
                            state_d = OVER;
                        end else begin
                            turn_d = other_player(turn_q);
                            pass_d = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    state_d = IDLE;
                    if (board_q[tgt_row_q][tgt_col_q] == EMPTY) begin
                        wr_en  = 1'b1;
                        wr_row = tgt_row_q;
                        wr_col = tgt_col_q;
                        wr_val = turn_q;
                        turn_d = other_player(turn_q);
                        pass_d = 1'b0;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
                CLEAR: begin
                    wr_en  = 1'b1;
                    wr_row = clr_row_q;
                    wr_col = clr_col_q;
                    wr_val = EMPTY;
                    if (clr_col_q == MAX_POS) begin
                        clr_col_d = 4'd0;
                        if (clr_row_q == MAX_POS) begin
                            state_d     = IDLE;
                            turn_d      = BLACK;
                            pass_d      = 1'b0;
                            center_load = 1'b1;
                        end else begin
                            clr_row_d = clr_row_q + 4'd1;
                        end
                    end else begin
                        clr_col_d = clr_col_q + 4'd1;
                    end
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d == CHECK) || (state_d == CLEAR);
        over_d = (state_d == OVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            turn_q    <= BLACK;
            pass_q    <= 1'b0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            over_q    <= 1'b0;
            tgt_row_q <= 4'd0;
            tgt_col_q <= 4'd0;
            clr_row_q <= 4'd0;
            clr_col_q <= 4'd0;
            board_q   <= '0;
        end else begin
            state_q   <= state_d;
            turn_q    <= turn_d;
            pass_q    <= pass_d;
            illegal_q <= illegal_d;
            busy_q    <= busy_d;
            over_q    <= over_d;
            tgt_row_q <= tgt_row_d;
            tgt_col_q <= tgt_col_d;
            clr_row_q <= clr_row_d;
            clr_col_q <= clr_col_d;
            if (wr_en) begin
                board_q[wr_row][wr_col] <= wr_val;
            end
        end
    end

    assign board     = board_q;
    assign turn      = turn_q;
    assign busy      = busy_q;
    assign illegal   = illegal_q;
    assign game_over = over_q;

endmodule

// File: doc/go_board_ctrl.md
GO_BOARD_CTRL -- requirements
Module: go_board_ctrl

Interface
REQ-001 Parameter: BOARD_N, default 9, board side length in intersections.
REQ-002 Ports: clk  in  1  system clock (65 MHz pixel clock domain).
REQ-003 Ports: reset  in  1  reset, asynchronous, active-high.
REQ-004 Ports: btn_up, btn_down, btn_left, btn_right  in  1 each  single-cycle cursor-move pulses, already debounced and synchronized to clk.
REQ-005 Ports: btn_place  in  1  single-cycle pulse, place stone at cursor.
REQ-006 Ports: btn_pass  in  1  single-cycle pulse, current player passes.
REQ-007 Ports: btn_clear  in  1  single-cycle pulse, start a new game.
REQ-008 Ports: board  out  [1:0] x [BOARD_N-1:0][BOARD_N-1:0]  cell state indexed [row][col]; 00 empty, 01 black, 10 white; 11 never driven.
REQ-009 Ports: cursor_row, cursor_col  out  4 each  cursor position, 0..BOARD_N-1.
REQ-010 Ports: turn  out  2  player to move (01 black, 10 white).
REQ-011 Ports: busy  out  1  high while in CHECK or CLEAR.
REQ-012 Ports: illegal  out  1  one-cycle pulse on rejected placement.
REQ-013 Ports: game_over  out  1  high in OVER state.

Function
REQ-014 FSM states: IDLE, CHECK, CLEAR, OVER; all outputs registered.
REQ-015 Cursor: each move pulse adjusts row/col by 1 on the next clock edge; saturates at 0 and BOARD_N-1 (no wrap).
REQ-016 Simultaneous up+down, or left+right, leave that axis unchanged; one vertical and one horizontal pulse in the same cycle both apply.
REQ-017 Cursor moves are accepted in IDLE and OVER, and ignored in CHECK and CLEAR.
REQ-018 IDLE + btn_place -> CHECK; the target (row,col) is latched in the same cycle.
REQ-019 CHECK lasts exactly one cycle. If the latched cell is 00: write turn into it, toggle turn, clear pass_cnt, and return to IDLE. Otherwise: pulse illegal, leave board and turn unchanged, and return to IDLE.
REQ-020 A written stone is visible on the board output 2 cycles after the btn_place pulse.
REQ-021 IDLE + btn_pass: toggle turn and increment the 1-bit-saturating pass_cnt. If pass_cnt was already 1 -> OVER instead, with turn unchanged.
REQ-022 OVER ignores btn_place and btn_pass; game_over=1.
REQ-023 btn_clear from any state -> CLEAR. The sweep writes 00 to one cell per cycle in row-major order (0,0)..(N-1,N-1), taking BOARD_N*BOARD_N cycles (81).
REQ-024 On CLEAR completion: turn=01, pass_cnt=0, cursor=(BOARD_N/2, BOARD_N/2), state -> IDLE.
REQ-025 A btn_clear during CLEAR restarts the sweep at cell (0,0).
REQ-026 Same-cycle priority: clear > place > pass; cursor moves still apply alongside place or pass.
REQ-027 Pulses arriving while busy=1, other than btn_clear, are dropped, not queued.

Reset
REQ-028 On reset assertion, asynchronously set: all cells 00, turn=01, cursor=(4,4) for the default BOARD_N, pass_cnt=0, state IDLE, illegal=0, busy=0, game_over=0.
REQ-029 Reset mid-CHECK or mid-CLEAR abandons the operation; no partial write survives except cells already cleared.
REQ-030 Deassertion is synchronous to clk by the upstream synchronizer; the block does no internal re-synchronization.

Structure
REQ-031 Shared package go_pkg holds: cell_t (2-bit) with constants EMPTY=00, BLACK=01, WHITE=10; BOARD_N; and the state enum.
REQ-032 Sub-module go_cursor holds the cursor saturation logic (REQ-015..017) with an enable input; the board array and FSM stay in go_board_ctrl.
REQ-033 board is a flop array, not BRAM, so the display can read any cell combinationally.

Verification
REQ-034 Reset, then btn_place at (4,4) -> board[4][4]=01 two cycles later, turn=10, illegal=0.
REQ-035 btn_place again at (4,4) -> illegal pulses exactly one cycle; board[4][4] stays 01; turn stays 10.
REQ-036 From (0,0), 3x btn_up plus 3x btn_left -> cursor stays (0,0). Then 12x btn_down -> row=8.
REQ-037 btn_pass twice consecutively -> game_over=1. A subsequent btn_place -> no board change.
REQ-038 After placing 3 stones, btn_clear -> busy=1 for 81 cycles, then all cells 00, turn=01, cursor=(4,4), game_over=0.
REQ-039 Assert reset at cycle 40 of a CLEAR sweep -> all outputs reach reset values without a clock edge; busy=0.
